// File: rtl/sga_uc_multi.sv
// ---------------------------------------------------------------------------
// sga_uc_multi
//
// Game control unit for the Snake Game Arcade with multiple lives.
// Sequences game start, apple placement, body rendering, paced movement,
// collision checking, growth, pause and respawn. It also owns the snake
// length (size) and the remaining-lives counter.
//
// Parameters
//   SIZE_W     width of size
//   INIT_SIZE  size loaded on game start and on respawn
//   MAX_SIZE   size that wins the game (INIT_SIZE < MAX_SIZE <= 2^SIZE_W-1)
//   LIVES      lives per game (1 .. 2^LIFE_W-1)
//   LIFE_W     width of lives_left
//
// Ports
//   clock          single clock, rising edge
//   restart        synchronous active-high reset
//   start          start / replay request (level)
//   pause          one-cycle pause-toggle pulse
//   is_at_apple    head is on the apple       (valid in COMPARA)
//   is_at_border   head is on the border      (valid in COMPARA)
//   is_at_body     head is on the snake body  (valid in COMPARA)
//   end_play_time  movement tick from the play-time pacer
//   render_finish  last body segment has been rendered
//   clear_size, count_size, render_clr, register_apple, reset_apple,
//   register_move, move, grow        datapath controls (Moore)
//   paused, finished, won, lost      status (Moore)
//   size           current snake length
//   lives_left     remaining lives
//   db_state       current state code, for debug
//
// Handshake note: there are no valid/ready channels here. Every input is a
// level or a single-cycle pulse sampled on the rising edge in the state that
// consumes it; inputs arriving in any other state are ignored.
//
// The Moore outputs are registered: they are decoded from the next state and
// loaded on the same edge as the state register, so each output always
// matches the decode of the current state, glitch-free.
// ---------------------------------------------------------------------------
module sga_uc_multi #(
  parameter int SIZE_W    = 6,
  parameter int INIT_SIZE = 1,
  parameter int MAX_SIZE  = 32,
  parameter int LIVES     = 3,
  parameter int LIFE_W    = 2
) (
  input  logic              clock,
  input  logic              restart,
  input  logic              start,
  input  logic              pause,
  input  logic              is_at_apple,
  input  logic              is_at_border,
  input  logic              is_at_body,
  input  logic              end_play_time,
  input  logic              render_finish,
  output logic              clear_size,
  output logic              count_size,
  output logic              render_clr,
  output logic              register_apple,
  output logic              reset_apple,
  output logic              register_move,
  output logic              move,
  output logic              grow,
  output logic              paused,
  output logic              finished,
  output logic              won,
  output logic              lost,
  output logic [SIZE_W-1:0] size,
  output logic [LIFE_W-1:0] lives_left,
  output logic [4:0]        db_state
);

  typedef enum logic [4:0] {
    IDLE              = 5'h00,
    PREPARA           = 5'h01,
    GERA_MACA_INICIAL = 5'h02,
    RENDERIZA         = 5'h03,
    ESPERA            = 5'h04,
    REGISTRA          = 5'h05,
    MOVE              = 5'h06,
    COMPARA           = 5'h07,
    COMEU_MACA        = 5'h08,
    CRESCE            = 5'h09,
    GERA_MACA         = 5'h0A,
    PAUSADO           = 5'h0B,
    FEZ_NADA          = 5'h0C,
    PERDEU            = 5'h0D,
    GANHOU            = 5'h0E,
    PROXIMO_RENDER    = 5'h0F,
    COLIDIU           = 5'h10,
    RENASCE           = 5'h11
  } state_t;

  // Output vector bit order:
  // {clear_size, count_size, render_clr, register_apple, reset_apple,
  //  register_move, move, grow, paused, finished, won, lost}
  localparam int OUT_W = 12;

  localparam logic [SIZE_W-1:0] INIT_SIZE_V = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W-1:0] MAX_SIZE_V  = SIZE_W'(MAX_SIZE);
  localparam logic [LIFE_W-1:0] LIVES_V     = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] ONE_LIFE    = LIFE_W'(1);

  state_t             state;
  state_t             state_next;
  logic [OUT_W-1:0]   out_q;
  logic [SIZE_W-1:0]  size_q;
  logic [LIFE_W-1:0]  lives_q;
  logic [SIZE_W-1:0]  size_inc;

  assign size_inc = size_q + SIZE_W'(1);

  // Moore decode of a state into the control/status vector.
  function automatic logic [OUT_W-1:0] decode(input state_t s);
    logic [OUT_W-1:0] o;
    o = '0;
    o[11] = (s == IDLE) || (s == PREPARA) || (s == RENASCE);   // clear_size
    o[10] = (s == RENDERIZA);                                   // count_size
    o[9]  = (s == IDLE) || (s == RENASCE);                      // render_clr
    o[8]  = (s == GERA_MACA_INICIAL) || (s == GERA_MACA);       // register_apple
    o[7]  = (s == COMEU_MACA);                                  // reset_apple
    o[6]  = (s == REGISTRA);                                    // register_move
    o[5]  = (s == MOVE);                                        // move
    o[4]  = (s == CRESCE);                                      // grow
    o[3]  = (s == PAUSADO);                                     // paused
    o[2]  = (s == GANHOU) || (s == PERDEU);                     // finished
    o[1]  = (s == GANHOU);                                      // won
    o[0]  = (s == PERDEU);                                      // lost
    return o;
  endfunction

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:              state_next = start ? PREPARA : IDLE;
      PREPARA:           state_next = GERA_MACA_INICIAL;
      GERA_MACA_INICIAL: state_next = RENDERIZA;
      RENDERIZA:         state_next = render_finish ? ESPERA : PROXIMO_RENDER;
      PROXIMO_RENDER:    state_next = RENDERIZA;
      ESPERA: begin
        // A pause arriving together with a tick wins; the tick is dropped.
        if (pause)              state_next = PAUSADO;
        else if (end_play_time) state_next = REGISTRA;
        else                    state_next = ESPERA;
      end
      PAUSADO:           state_next = pause ? ESPERA : PAUSADO;
      REGISTRA:          state_next = MOVE;
      MOVE:              state_next = COMPARA;
      COMPARA: begin
        // A collision takes priority over eating an apple.
        if (is_at_border || is_at_body) state_next = COLIDIU;
        else if (is_at_apple)           state_next = COMEU_MACA;
        else                            state_next = FEZ_NADA;
      end
      COMEU_MACA:        state_next = CRESCE;
      CRESCE:            state_next = (size_inc == MAX_SIZE_V) ? GANHOU : GERA_MACA;
      GERA_MACA:         state_next = RENDERIZA;
      FEZ_NADA:          state_next = RENDERIZA;
      COLIDIU:           state_next = (lives_q == ONE_LIFE) ? PERDEU : RENASCE;
      // The current apple stays where it is across a respawn.
      RENASCE:           state_next = RENDERIZA;
      PERDEU:            state_next = start ? PREPARA : PERDEU;
      GANHOU:            state_next = start ? PREPARA : GANHOU;
      default:           state_next = IDLE;
    endcase
  end

  // State, registered outputs, size and lives registers.
  always_ff @(posedge clock) begin
    if (restart) begin
      state   <= IDLE;
      out_q   <= decode(IDLE);
      size_q  <= '0;
      lives_q <= '0;
    end else begin
      state <= state_next;
      out_q <= decode(state_next);
      case (state)
        PREPARA: begin
          size_q  <= INIT_SIZE_V;
          lives_q <= LIVES_V;
        end
        CRESCE:  size_q <= size_inc;
        // lives_q is at least 1 here, so the decrement never wraps and the
        // last life lands on exactly 0.
        COLIDIU: lives_q <= lives_q - ONE_LIFE;
        RENASCE: size_q <= INIT_SIZE_V;
        default: ;
      endcase
    end
  end

  assign clear_size     = out_q[11];
  assign count_size     = out_q[10];
  assign render_clr     = out_q[9];
  assign register_apple = out_q[8];
  assign reset_apple    = out_q[7];
  assign register_move  = out_q[6];
  assign move           = out_q[5];
  assign grow           = out_q[4];
  assign paused         = out_q[3];
  assign finished       = out_q[2];
  assign won            = out_q[1];
  assign lost           = out_q[0];

  assign size       = size_q;
  assign lives_left = lives_q;
  assign db_state   = state;

endmodule

// File: tb/tb_sga_uc_multi.sv
// ---------------------------------------------------------------------------
// Testbench for sga_uc_multi (MAX_SIZE = 3 so a win is reachable quickly).
// A table of per-cycle vectors drives a full game: start, render, apple,
// three collisions to a loss, replay, two apples to a win, pause, and resets
// in the middle of a render and during pause. Each vector lists the inputs
// applied before a rising edge and the expected state, size and lives just
// after it; the Moore outputs are checked against a decode of the expected
// state. A few hand-written sequences then check pulse counts.
// ---------------------------------------------------------------------------
module tb_sga_uc_multi;

  localparam int SIZE_W = 6;
  localparam int LIFE_W = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic restart, start, pause, is_at_apple, is_at_border, is_at_body;
  logic end_play_time, render_finish;
  logic clear_size, count_size, render_clr, register_apple, reset_apple;
  logic register_move, move, grow, paused, finished, won, lost;
  logic [SIZE_W-1:0] size;
  logic [LIFE_W-1:0] lives_left;
  logic [4:0]        db_state;

  sga_uc_multi #(
    .SIZE_W(SIZE_W), .INIT_SIZE(1), .MAX_SIZE(3), .LIVES(3), .LIFE_W(LIFE_W)
  ) dut (
    .clock(clock), .restart(restart), .start(start), .pause(pause),
    .is_at_apple(is_at_apple), .is_at_border(is_at_border),
    .is_at_body(is_at_body), .end_play_time(end_play_time),
    .render_finish(render_finish),
    .clear_size(clear_size), .count_size(count_size), .render_clr(render_clr),
    .register_apple(register_apple), .reset_apple(reset_apple),
    .register_move(register_move), .move(move), .grow(grow),
    .paused(paused), .finished(finished), .won(won), .lost(lost),
    .size(size), .lives_left(lives_left), .db_state(db_state)
  );

  // ---------------- vector table ----------------
  // Input mask bits: {restart, start, pause, apple, border, body, tick, rfin}
  localparam logic [7:0] N  = 8'h00;
  localparam logic [7:0] RS = 8'h80;
  localparam logic [7:0] ST = 8'h40;
  localparam logic [7:0] PZ = 8'h20;
  localparam logic [7:0] AP = 8'h10;
  localparam logic [7:0] BR = 8'h08;
  localparam logic [7:0] BD = 8'h04;
  localparam logic [7:0] TK = 8'h02;
  localparam logic [7:0] RF = 8'h01;

  typedef struct {
    logic [7:0] in;
    logic [4:0] exp_state;
    int         exp_size;
    int         exp_lives;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic [7:0] in, input logic [4:0] s,
                     input int sz, input int lv);
    vec_t v;
    v.in = in; v.exp_state = s; v.exp_size = sz; v.exp_lives = lv;
    vecs.push_back(v);
  endtask

  // Expected Moore outputs for a state, from the output table.
  function automatic logic [11:0] exp_outs(input logic [4:0] s);
    logic [11:0] o;
    o = '0;
    o[11] = (s == 5'h00) || (s == 5'h01) || (s == 5'h11);
    o[10] = (s == 5'h03);
    o[9]  = (s == 5'h00) || (s == 5'h11);
    o[8]  = (s == 5'h02) || (s == 5'h0A);
    o[7]  = (s == 5'h08);
    o[6]  = (s == 5'h05);
    o[5]  = (s == 5'h06);
    o[4]  = (s == 5'h09);
    o[3]  = (s == 5'h0B);
    o[2]  = (s == 5'h0D) || (s == 5'h0E);
    o[1]  = (s == 5'h0E);
    o[0]  = (s == 5'h0D);
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [7:0] in);
    {restart, start, pause, is_at_apple, is_at_border, is_at_body,
     end_play_time, render_finish} = in;
  endtask

  task automatic step(input logic [7:0] in);
    drive(in);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] dut_outs();
    return {clear_size, count_size, render_clr, register_apple, reset_apple,
            register_move, move, grow, paused, finished, won, lost};
  endfunction

  int cnt_count, cnt_reset_apple, cnt_grow;
  bit reached;

  initial begin
    drive(N);

    // ---- reset and start ----
    add(RS,      5'h00, 0, 0);
    add(N,       5'h00, 0, 0);
    add(ST,      5'h01, 0, 0);
    add(N,       5'h02, 1, 3);
    add(N,       5'h03, 1, 3);
    add(N,       5'h0F, 1, 3);
    add(N,       5'h03, 1, 3);
    add(N,       5'h0F, 1, 3);
    add(N,       5'h03, 1, 3);
    add(RF,      5'h04, 1, 3);
    add(N,       5'h04, 1, 3);
    // ---- apple and growth ----
    add(TK,      5'h05, 1, 3);
    add(N,       5'h06, 1, 3);
    add(N,       5'h07, 1, 3);
    add(AP,      5'h08, 1, 3);
    add(N,       5'h09, 1, 3);
    add(N,       5'h0A, 2, 3);
    add(N,       5'h03, 2, 3);
    add(RF,      5'h04, 2, 3);
    // ---- collision 1: border and apple together ----
    add(TK,      5'h05, 2, 3);
    add(N,       5'h06, 2, 3);
    add(N,       5'h07, 2, 3);
    add(AP|BR,   5'h10, 2, 3);
    add(N,       5'h11, 2, 2);
    add(N,       5'h03, 1, 2);
    add(RF,      5'h04, 1, 2);
    // ---- collision 2: body ----
    add(TK,      5'h05, 1, 2);
    add(N,       5'h06, 1, 2);
    add(N,       5'h07, 1, 2);
    add(BD,      5'h10, 1, 2);
    add(N,       5'h11, 1, 1);
    add(N,       5'h03, 1, 1);
    add(RF,      5'h04, 1, 1);
    // ---- collision 3: last life ----
    add(TK,      5'h05, 1, 1);
    add(N,       5'h06, 1, 1);
    add(N,       5'h07, 1, 1);
    add(BR,      5'h10, 1, 1);
    add(N,       5'h0D, 1, 0);
    add(N,       5'h0D, 1, 0);
    // ---- replay ----
    add(ST,      5'h01, 1, 0);
    add(N,       5'h02, 1, 3);
    add(N,       5'h03, 1, 3);
    add(RF,      5'h04, 1, 3);
    // ---- two apples to win ----
    add(TK,      5'h05, 1, 3);
    add(N,       5'h06, 1, 3);
    add(N,       5'h07, 1, 3);
    add(AP,      5'h08, 1, 3);
    add(N,       5'h09, 1, 3);
    add(N,       5'h0A, 2, 3);
    add(N,       5'h03, 2, 3);
    add(RF,      5'h04, 2, 3);
    add(TK,      5'h05, 2, 3);
    add(N,       5'h06, 2, 3);
    add(N,       5'h07, 2, 3);
    add(AP,      5'h08, 2, 3);
    add(N,       5'h09, 2, 3);
    add(N,       5'h0E, 3, 3);
    add(N,       5'h0E, 3, 3);
    add(ST,      5'h01, 3, 3);
    add(N,       5'h02, 1, 3);
    add(N,       5'h03, 1, 3);
    add(RF,      5'h04, 1, 3);
    // ---- pause: tick in same cycle is dropped, later inputs ignored ----
    add(PZ|TK,   5'h0B, 1, 3);
    add(TK,      5'h0B, 1, 3);
    add(ST|TK|BR|AP, 5'h0B, 1, 3);
    add(PZ,      5'h04, 1, 3);
    add(TK,      5'h05, 1, 3);
    add(N,       5'h06, 1, 3);
    add(N,       5'h07, 1, 3);
    add(N,       5'h0C, 1, 3);
    add(N,       5'h03, 1, 3);
    add(N,       5'h0F, 1, 3);
    // ---- reset in PROXIMO_RENDER ----
    add(RS,      5'h00, 0, 0);
    add(N,       5'h00, 0, 0);
    add(ST,      5'h01, 0, 0);
    add(N,       5'h02, 1, 3);
    add(N,       5'h03, 1, 3);
    add(RF,      5'h04, 1, 3);
    add(PZ,      5'h0B, 1, 3);
    // ---- reset in PAUSADO, reset beats start ----
    add(RS|ST,   5'h00, 0, 0);
    add(N,       5'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in);
      chk($sformatf("v%0d db_state", i), int'(db_state),   int'(vecs[i].exp_state));
      chk($sformatf("v%0d size", i),     int'(size),       vecs[i].exp_size);
      chk($sformatf("v%0d lives", i),    int'(lives_left), vecs[i].exp_lives);
      chk($sformatf("v%0d outs", i),     int'(dut_outs()), int'(exp_outs(vecs[i].exp_state)));
    end

    // ---- hand sequence: single-segment render gives one count_size ----
    step(RS);
    step(ST);
    cnt_count = 0;
    reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (count_size) cnt_count++;
      if (db_state == 5'h04) reached = 1;
      else step((db_state == 5'h03) ? RF : N);
    end
    chk("seq1 reach ESPERA", int'(reached), 1);
    chk("seq1 count_size pulses", cnt_count, 1);

    // ---- hand sequence: one apple gives one reset_apple and one grow ----
    step(TK);
    chk("seq2 tick latency", int'(register_move), 1);
    cnt_reset_apple = 0;
    cnt_grow = 0;
    reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (reset_apple) cnt_reset_apple++;
      if (grow) cnt_grow++;
      if (db_state == 5'h04) reached = 1;
      else step((db_state == 5'h03) ? RF : AP);
    end
    chk("seq2 reach ESPERA", int'(reached), 1);
    chk("seq2 reset_apple pulses", cnt_reset_apple, 1);
    chk("seq2 grow pulses", cnt_grow, 1);
    chk("seq2 size", int'(size), 2);

    // ---- hand sequence: move with no event reaches RENDERIZA 5th cycle ----
    step(TK);
    step(N);
    step(N);
    step(N);
    chk("seq3 FEZ_NADA", int'(db_state), 'h0C);
    step(N);
    chk("seq3 RENDERIZA", int'(db_state), 'h03);
    chk("seq3 count_size", int'(count_size), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sga_uc_multi.md
# sga_uc_multi

Parametrised game control unit for the Snake Game Arcade, successor of the single-life control FSM. It sequences start, apple placement, body rendering, paced movement, collision checking, growth, pause and a multi-life respawn. It also owns the snake size and remaining-lives registers. It sits between the player inputs and play-time pacer on one side and the datapath (snake body memory, apple generator, renderer) on the other.

## Interface
- `SIZE_W`, default 6: width of the `size` register.
- `INIT_SIZE`, default 1: size loaded on game start and on respawn.
- `MAX_SIZE`, default 32: size that wins the game. Legal range is INIT_SIZE < MAX_SIZE ≤ 2^SIZE_W−1.
- `LIVES`, default 3: lives per game. Must be ≥1 and ≤2^LIFE_W−1.
- `LIFE_W`, default 2: width of `lives_left`.
- `clock` in 1: the single clock. All state changes on its rising edge.
- `restart` in 1: synchronous, active-high reset.
- `start` in 1: start or replay request, level-sampled.
- `pause` in 1: one-cycle pause-toggle pulse, already edge-detected upstream.
- `is_at_apple`, `is_at_border`, `is_at_body` in 1 each: head-position flags, valid in COMPARA.
- `end_play_time` in 1: movement tick from the play-time pacer.
- `render_finish` in 1: last body segment has been rendered.
- `clear_size`, `count_size`, `render_clr`, `register_apple`, `reset_apple` out 1 each: datapath controls.
- `register_move`, `move`, `grow` out 1 each: datapath controls.
- `paused`, `finished`, `won`, `lost` out 1 each: status.
- `size` out SIZE_W: current snake length.
- `lives_left` out LIFE_W: remaining lives.
- `db_state` out 5: state code for debug.

## Operation
State codes are in hex.
- IDLE 00
  - `start` → PREPARA; otherwise stay.
- PREPARA 01
  - Load `size` with INIT_SIZE and `lives_left` with LIVES.
  - → GERA_MACA_INICIAL.
- GERA_MACA_INICIAL 02 → RENDERIZA.
- RENDERIZA 03
  - `render_finish` → ESPERA; otherwise → PROXIMO_RENDER 0F.
- PROXIMO_RENDER 0F → RENDERIZA.
- ESPERA 04
  - `pause` → PAUSADO 0B. Otherwise `end_play_time` → REGISTRA. Otherwise stay.
  - If both arrive together, `pause` wins and that tick is dropped.
- PAUSADO 0B
  - `pause` → ESPERA. `end_play_time`, `start` and the position flags are ignored.
- REGISTRA 05 → MOVE 06 → COMPARA 07.
- COMPARA 07
  - (`is_at_border` | `is_at_body`) → COLIDIU 10.
  - Otherwise `is_at_apple` → COMEU_MACA 08.
  - Otherwise → FEZ_NADA 0C.
  - A collision takes priority over an apple.
- COMEU_MACA 08 → CRESCE 09.
- CRESCE 09
  - `size` ← `size`+1.
  - If `size`+1 == MAX_SIZE → GANHOU 0E; otherwise → GERA_MACA 0A.
- GERA_MACA 0A → RENDERIZA.
- FEZ_NADA 0C → RENDERIZA.
- COLIDIU 10
  - If `lives_left` == 1: `lives_left` ← 0 and → PERDEU 0D.
  - Otherwise: `lives_left` ← `lives_left`−1 and → RENASCE 11.
- RENASCE 11
  - `size` ← INIT_SIZE. The current apple is kept.
  - → RENDERIZA.
- PERDEU 0D and GANHOU 0E
  - `start` → PREPARA; otherwise hold.
- Any unused code → IDLE.

Moore outputs, each decoded from the current state only:
- `clear_size` = IDLE | PREPARA | RENASCE
- `count_size` = RENDERIZA
- `render_clr` = IDLE | RENASCE
- `register_apple` = GERA_MACA_INICIAL | GERA_MACA
- `reset_apple` = COMEU_MACA
- `register_move` = REGISTRA
- `move` = MOVE
- `grow` = CRESCE
- `paused` = PAUSADO
- `won` = GANHOU
- `lost` = PERDEU
- `finished` = GANHOU | PERDEU
- `db_state` = the state code.

Registers:
- `size` and `lives_left` change only in PREPARA, CRESCE, COLIDIU and RENASCE.
- Both arithmetic operations are SIZE_W or LIFE_W wide with no wrap. The parameter constraints make wrap unreachable.

## Timing
- `restart` is sampled at the rising edge. On the next edge the FSM is in IDLE, `size` = 0 and `lives_left` = 0.
  - In that reset state `clear_size` = 1 and `render_clr` = 1. Every other output is 0 and `db_state` = 00.
  - `restart` overrides every transition, including mid-render and PAUSADO.
- Each state lasts exactly one cycle, except the waits in IDLE, ESPERA, PAUSADO, PERDEU and GANHOU.
- `end_play_time` to `register_move` takes 1 cycle: ESPERA samples the tick, and the next cycle is REGISTRA.
- Move cycle with no event: REGISTRA, MOVE, COMPARA, FEZ_NADA, then RENDERIZA, i.e. RENDERIZA in the 5th cycle after ESPERA.
- Render loop takes 2 cycles per segment (RENDERIZA/PROXIMO_RENDER). `count_size` pulses once per segment, including the final segment.
- `size` and `lives_left` update on the edge that leaves CRESCE, COLIDIU or RENASCE. The new value is visible in the following state.

## Test plan
- **Start and idle.** Assert `restart`, then hold `start` = 1 for 1 cycle. Required `db_state` sequence: 00, 01, 02, 03. After PREPARA, `size` = 1 and `lives_left` = 3. With `render_finish` = 0 for 2 segments, `count_size` pulses 3 times before ESPERA.
- **Apple and growth.** Apply `end_play_time` with `is_at_apple` = 1 in COMPARA. Required sequence: 05, 06, 07, 08, 09, 0A, 03. `reset_apple` and `grow` pulse once each and `size` becomes 2.
- **Collision priority and lives.** Set `is_at_apple` = `is_at_border` = 1. Required: COLIDIU, `lives_left` goes 3→2, then RENASCE with `size` back to 1, then RENDERIZA. Repeat two more times: the third collision gives PERDEU with `lost` = `finished` = 1 and `lives_left` = 0.
- **Win.** Use MAX_SIZE = 3 and eat 2 apples. Required: after the second CRESCE the state is GANHOU, `won` = 1 and `size` = 3. `start` then goes to PREPARA, which reloads `size` and `lives_left`.
- **Pause.** In ESPERA, assert `pause` and `end_play_time` in the same cycle. Required: PAUSADO, `paused` = 1, no REGISTRA. Further ticks are ignored. A second `pause` pulse returns to ESPERA.
- **Reset mid-operation.** Assert `restart` in PROXIMO_RENDER and again in PAUSADO. Required: IDLE on the next edge, with `size` = 0 and `lives_left` = 0.
